// File: rtl/read_words_to_slices_if.sv
// Interface bundling the generator's control, output stream and memory port.
//   base/count/_start : transfer request (sampled when _start=1)
//   _ready/_valid/_done/_out0 : ready/valid slice stream with terminal done beat
//   mem_req/mem_addr/mem_ack/mem_rdata : single-outstanding req/ack read port
// Modport master is the generator side; slave is the environment side.
interface read_words_to_slices_if #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int SLICE_W = 8
);
  logic [ADDR_W-1:0]  base;
  logic [31:0]        count;
  logic               _start;
  logic               _ready;
  logic               _valid;
  logic               _done;
  logic [SLICE_W-1:0] _out0;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [WORD_W-1:0]  mem_rdata;

  modport master (
    input  base, count, _start, _ready, mem_ack, mem_rdata,
    output _valid, _done, _out0, mem_req, mem_addr
  );

  modport slave (
    output base, count, _start, _ready, mem_ack, mem_rdata,
    input  _valid, _done, _out0, mem_req, mem_addr
  );
endinterface

// File: rtl/read_words_to_slices.sv
// Word-to-slice reader: on _start fetches `count` words from base, base+STRIDE, ...
// over a req/ack memory port and streams each word as WORD_W/SLICE_W slices on a
// ready/valid output, closing with a done beat.
// Ports:
//   _clock    : clock, rising edge
//   _reset_n  : asynchronous active-low reset
//   bus       : read_words_to_slices_if.master (request, slice stream, memory port)
// WORD_W must be an integer multiple of SLICE_W.
module read_words_to_slices #(
  parameter int          ADDR_W    = 32,
  parameter int          WORD_W    = 32,
  parameter int          SLICE_W   = 8,
  parameter int unsigned STRIDE    = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                   _clock,
  input  logic                   _reset_n,
  read_words_to_slices_if.master bus
);

  localparam int NUM_SLC = WORD_W / SLICE_W;
  localparam int KW      = (NUM_SLC > 1) ? $clog2(NUM_SLC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SLC - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [KW-1:0]       k_q, k_d, k_inc;
  logic [31:0]         i_q, i_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [SLICE_W-1:0]  out_q, out_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                more_words;

  // Slice views of the incoming read data (for slice 0) and the latched word.
  logic [NUM_SLC-1:0][SLICE_W-1:0] rd_slc, wq_slc;

  for (genvar j = 0; j < NUM_SLC; j++) begin : g_slc
    if (MSB_FIRST) begin : g_msb
      assign rd_slc[j] = bus.mem_rdata[WORD_W-1-j*SLICE_W -: SLICE_W];
      assign wq_slc[j] = word_q[WORD_W-1-j*SLICE_W -: SLICE_W];
    end else begin : g_lsb
      assign rd_slc[j] = bus.mem_rdata[j*SLICE_W +: SLICE_W];
      assign wq_slc[j] = word_q[j*SLICE_W +: SLICE_W];
    end
  end

  assign k_inc = k_q + 1'b1;
  // 33-bit compare so i+1 cannot wrap when count is near 2^32.
  assign more_words = ({1'b0, i_q} + 33'd1) < {1'b0, cnt_q};

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      k_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      k_q     <= k_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out_q   <= out_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    k_d     = k_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = done_q;
    out_d   = out_q;
    req_d   = req_q;
    addr_d  = addr_q;

    if (bus._start) begin
      // Restart beats everything: any in-flight beat or ack this cycle is dropped.
      cnt_d = bus.count;
      i_d   = '0;
      k_d   = '0;
      if (bus.count == 32'd0) begin
        // Empty transfer goes straight to the done beat with a zero slice.
        state_d = DONE;
        valid_d = 1'b1;
        done_d  = 1'b1;
        out_d   = '0;
        req_d   = 1'b0;
      end else begin
        state_d = FETCH;
        valid_d = 1'b0;
        done_d  = 1'b0;
        req_d   = 1'b1;
        addr_d  = bus.base;
      end
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          if (bus.mem_ack) begin
            word_d  = bus.mem_rdata;
            req_d   = 1'b0;
            out_d   = rd_slc[0];
            valid_d = 1'b1;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (valid_q && bus._ready) begin
            if (k_q != K_LAST) begin
              k_d   = k_inc;
              out_d = wq_slc[k_inc];
            end else begin
              k_d = '0;
              i_d = i_q + 32'd1;
              if (more_words) begin
                state_d = FETCH;
                valid_d = 1'b0;
                req_d   = 1'b1;
                addr_d  = addr_q + ADDR_W'(STRIDE);
              end else begin
                // Done beat keeps the last slice on _out0.
                state_d = DONE;
                valid_d = 1'b1;
                done_d  = 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (bus._ready) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus._valid   = valid_q;
  assign bus._done    = done_q;
  assign bus._out0    = out_q;
  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;

endmodule

// File: tb/tb_read_words_to_slices.sv
// Directed bench for read_words_to_slices: LSB-first 32->8 instance plus an
// MSB-first 32->16 instance. Inputs change on the falling edge, outputs are
// sampled there too.
module tb_read_words_to_slices;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  read_words_to_slices_if #(.ADDR_W(32), .WORD_W(32), .SLICE_W(8))  b1 ();
  read_words_to_slices_if #(.ADDR_W(32), .WORD_W(32), .SLICE_W(16)) b2 ();

  read_words_to_slices #(.ADDR_W(32), .WORD_W(32), .SLICE_W(8), .STRIDE(4), .MSB_FIRST(1'b0))
    u_dut (._clock(clk), ._reset_n(rst_n), .bus(b1));
  read_words_to_slices #(.ADDR_W(32), .WORD_W(32), .SLICE_W(16), .STRIDE(4), .MSB_FIRST(1'b1))
    u_msb (._clock(clk), ._reset_n(rst_n), .bus(b2));

  int n_vec = 0;
  int n_err = 0;
  int hold_chk = 0;

  logic [7:0]  beat_q[$];
  logic        done_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] wq[$];
  logic [7:0]  exp_q[$];

  // Expected LSB-first byte stream for the words in wq, plus the done beat.
  function automatic void build_exp();
    exp_q.delete();
    foreach (wq[w])
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((wq[w] >> (8 * k)) & 32'hFF));
    exp_q.push_back(exp_q[exp_q.size() - 1]);
  endfunction

  task automatic start1(input logic [31:0] base, input logic [31:0] cnt);
    @(negedge clk);
    b1.base = base; b1.count = cnt; b1._start = 1'b1;
  endtask

  // Runs memory model (ack on lat-th cycle of a request, data = addr + mem_off)
  // and the consumer (ready from rdy_pat), recording beats and addresses.
  task automatic run_stream(input int lat, input logic [31:0] rdy_pat, input logic [31:0] mem_off,
                            input int stop_beats, input int max_cyc);
    int cyc = 0;
    int cnt = 0;
    logic pend = 1'b0;
    logic [7:0] p_out = '0;
    bit fin = 1'b0;
    beat_q.delete(); done_q.delete(); addr_q.delete();
    while (!fin && cyc < max_cyc) begin
      @(negedge clk);
      b1._start = 1'b0;
      if (pend) begin
        n_vec++; hold_chk++;
        if (b1._valid !== 1'b1 || b1._out0 !== p_out) begin
          n_err++;
          $display("FAIL hold: valid=%b out0=%h, required valid=1 out0=%h", b1._valid, b1._out0, p_out);
        end
      end
      b1._ready = rdy_pat[cyc % 32];
      b1.mem_ack = 1'b0;
      if (b1.mem_req) begin
        if (cnt == 0) addr_q.push_back(b1.mem_addr);
        cnt++;
        if (cnt == lat) begin
          b1.mem_ack = 1'b1;
          b1.mem_rdata = b1.mem_addr + mem_off;
          cnt = 0;
        end
      end
      pend  = b1._valid && !b1._ready;
      p_out = b1._out0;
      if (b1._valid && b1._ready) begin
        beat_q.push_back(b1._out0);
        done_q.push_back(b1._done);
        if (b1._done || (stop_beats > 0 && beat_q.size() == stop_beats)) fin = 1'b1;
      end
      cyc++;
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d beats after %0d cycles", beat_q.size(), cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1._start = 0; b1._ready = 0; b1.mem_ack = 0; b1.mem_rdata = '0; b1.base = '0; b1.count = '0;
    b2._start = 0; b2._ready = 0; b2.mem_ack = 0; b2.mem_rdata = '0; b2.base = '0; b2.count = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({b1._valid, b1._done, b1._out0, b1.mem_req, b1.mem_addr} !== 43'd0) begin
      n_err++;
      $display("FAIL reset8: valid=%b done=%b out0=%h req=%b addr=%h, required all 0",
               b1._valid, b1._done, b1._out0, b1.mem_req, b1.mem_addr);
    end
    n_vec++;
    if ({b2._valid, b2._done, b2._out0, b2.mem_req, b2.mem_addr} !== 51'd0) begin
      n_err++;
      $display("FAIL reset16: valid=%b done=%b out0=%h req=%b addr=%h, required all 0",
               b2._valid, b2._done, b2._out0, b2.mem_req, b2.mem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [9];
    exp_b = '{8'hA4, 8'h01, 8'h00, 8'h00, 8'hA8, 8'h01, 8'h00, 8'h00, 8'h00};
    start1(32'h100, 32'd2);
    // words 0x1A4 / 0x1A8 at 0x100 / 0x104
    run_stream(2, 32'hFFFF_FFFF, 32'd420 - 32'h100, 0, 100);
    n_vec++;
    if (beat_q.size() != 9) begin
      n_err++; $display("FAIL basic_len: got %0d beats, required 9", beat_q.size());
    end
    for (int k = 0; k < 9 && k < beat_q.size(); k++) begin
      n_vec++;
      if (beat_q[k] !== exp_b[k] || done_q[k] !== (k == 8)) begin
        n_err++;
        $display("FAIL basic_beat%0d: out0=%h done=%b, required out0=%h done=%b",
                 k, beat_q[k], done_q[k], exp_b[k], (k == 8));
      end
    end
    n_vec++;
    if (addr_q.size() != 2 || addr_q[0] !== 32'h100 || addr_q[1] !== 32'h104) begin
      n_err++; $display("FAIL basic_addr: got %0d addrs first=%h, required 00000100,00000104",
                        addr_q.size(), addr_q.size() > 0 ? addr_q[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    wq.delete(); wq.push_back(32'h1234_5640); wq.push_back(32'h1234_5644);
    build_exp();
    hold_chk = 0;
    start1(32'h40, 32'd2);
    run_stream(2, 32'h9999_9999, 32'h1234_5600, 0, 200);
    n_vec++;
    if (beat_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_len: got %0d beats, required %0d", beat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < beat_q.size(); k++) begin
      n_vec++;
      if (beat_q[k] !== exp_q[k] || done_q[k] !== (k == exp_q.size() - 1)) begin
        n_err++; $display("FAIL bp_beat%0d: out0=%h done=%b, required out0=%h", k, beat_q[k], done_q[k], exp_q[k]);
      end
    end
    n_vec++;
    if (hold_chk == 0) begin
      n_err++; $display("FAIL bp_stalls: got 0 stall cycles, required >0");
    end
  endtask

  task automatic test_count_zero();
    start1(32'h300, 32'd0);
    b1._ready = 1'b0;
    @(negedge clk);
    b1._start = 1'b0;
    n_vec++;
    if (b1._valid !== 1'b1 || b1._done !== 1'b1 || b1._out0 !== 8'h00 || b1.mem_req !== 1'b0) begin
      n_err++; $display("FAIL zero_done: valid=%b done=%b out0=%h req=%b, required 1 1 00 0",
                        b1._valid, b1._done, b1._out0, b1.mem_req);
    end
    @(negedge clk);
    n_vec++;
    if (b1._valid !== 1'b1 || b1._done !== 1'b1 || b1.mem_req !== 1'b0) begin
      n_err++; $display("FAIL zero_hold: valid=%b done=%b req=%b, required 1 1 0", b1._valid, b1._done, b1.mem_req);
    end
    b1._ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (b1._valid !== 1'b0 || b1._done !== 1'b0 || b1.mem_req !== 1'b0) begin
      n_err++; $display("FAIL zero_idle: valid=%b done=%b req=%b, required 0 0 0", b1._valid, b1._done, b1.mem_req);
    end
  endtask

  task automatic test_msb_first();
    logic [15:0] exp_o [3];
    logic        exp_d [3];
    int w = 0;
    exp_o = '{16'hDEAD, 16'hBEEF, 16'hBEEF};
    exp_d = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    b2.base = 32'h0; b2.count = 32'd1; b2._start = 1'b1; b2._ready = 1'b1;
    @(negedge clk);
    b2._start = 1'b0;
    while (b2.mem_req !== 1'b1 && w < 5) begin @(negedge clk); w++; end
    n_vec++;
    if (b2.mem_req !== 1'b1 || b2.mem_addr !== 32'h0) begin
      n_err++; $display("FAIL msb_req: req=%b addr=%h, required 1 00000000", b2.mem_req, b2.mem_addr);
    end
    b2.mem_ack = 1'b1; b2.mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b2.mem_ack = 1'b0;
      n_vec++;
      if (b2._valid !== 1'b1 || b2._out0 !== exp_o[k] || b2._done !== exp_d[k]) begin
        n_err++; $display("FAIL msb_beat%0d: valid=%b out0=%h done=%b, required 1 %h %b",
                          k, b2._valid, b2._out0, b2._done, exp_o[k], exp_d[k]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (b2._valid !== 1'b0 || b2._done !== 1'b0) begin
      n_err++; $display("FAIL msb_idle: valid=%b done=%b, required 0 0", b2._valid, b2._done);
    end
  endtask

  task automatic test_reset_mid_emit();
    start1(32'h100, 32'd2);
    run_stream(2, 32'hFFFF_FFFF, 32'd420 - 32'h100, 5, 100);
    @(posedge clk);
    #2;
    n_vec++;
    if (b1._valid !== 1'b1 || b1._out0 !== 8'h01) begin
      n_err++; $display("FAIL rst_pre: valid=%b out0=%h, required 1 01", b1._valid, b1._out0);
    end
    b1._ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({b1._valid, b1._done, b1._out0, b1.mem_req, b1.mem_addr} !== 43'd0) begin
      n_err++; $display("FAIL rst_async: valid=%b done=%b out0=%h req=%b addr=%h, required all 0",
                        b1._valid, b1._done, b1._out0, b1.mem_req, b1.mem_addr);
    end
    b1.mem_ack = 1'b1; b1.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b1.mem_ack = 1'b0;
    n_vec++;
    if (b1._valid !== 1'b0 || b1.mem_req !== 1'b0 || b1._out0 !== 8'h00) begin
      n_err++; $display("FAIL rst_late_ack: valid=%b req=%b out0=%h, required 0 0 00", b1._valid, b1.mem_req, b1._out0);
    end
    wq.delete(); wq.push_back(32'h1A4); wq.push_back(32'h1A8);
    build_exp();
    start1(32'h100, 32'd2);
    run_stream(2, 32'hFFFF_FFFF, 32'd420 - 32'h100, 0, 100);
    n_vec++;
    if (beat_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_len: got %0d beats, required %0d", beat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < beat_q.size(); k++) begin
      n_vec++;
      if (beat_q[k] !== exp_q[k] || done_q[k] !== (k == exp_q.size() - 1)) begin
        n_err++; $display("FAIL rst_beat%0d: out0=%h done=%b, required out0=%h", k, beat_q[k], done_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_restart_fetch();
    start1(32'h100, 32'd3);
    @(negedge clk);
    b1._start = 1'b0;
    n_vec++;
    if (b1.mem_req !== 1'b1 || b1.mem_addr !== 32'h100) begin
      n_err++; $display("FAIL rs_fetch: req=%b addr=%h, required 1 00000100", b1.mem_req, b1.mem_addr);
    end
    // restart and an ack land in the same cycle; the ack must be dropped
    b1.base = 32'h200; b1.count = 32'd3; b1._start = 1'b1;
    b1.mem_ack = 1'b1; b1.mem_rdata = 32'hBADB_AD00;
    @(negedge clk);
    b1._start = 1'b0; b1.mem_ack = 1'b0;
    n_vec++;
    if (b1.mem_req !== 1'b1 || b1.mem_addr !== 32'h200 || b1._valid !== 1'b0) begin
      n_err++; $display("FAIL rs_new: req=%b addr=%h valid=%b, required 1 00000200 0", b1.mem_req, b1.mem_addr, b1._valid);
    end
    wq.delete(); wq.push_back(32'hA000_0200); wq.push_back(32'hA000_0204); wq.push_back(32'hA000_0208);
    build_exp();
    run_stream(2, 32'hFFFF_FFFF, 32'hA000_0000, 0, 200);
    n_vec++;
    if (addr_q.size() != 3 || addr_q[0] !== 32'h200 || addr_q[1] !== 32'h204 || addr_q[2] !== 32'h208) begin
      n_err++; $display("FAIL rs_addr: got %0d addrs, required 00000200,00000204,00000208", addr_q.size());
    end
    n_vec++;
    if (beat_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rs_len: got %0d beats, required %0d", beat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < beat_q.size(); k++) begin
      n_vec++;
      if (beat_q[k] !== exp_q[k] || done_q[k] !== (k == exp_q.size() - 1)) begin
        n_err++; $display("FAIL rs_beat%0d: out0=%h done=%b, required out0=%h", k, beat_q[k], done_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    // words: FFFFFFFC+0x11 wraps to 0x0000000D, then 0x00000011
    wq.delete(); wq.push_back(32'h0000_000D); wq.push_back(32'h0000_0011);
    build_exp();
    start1(32'hFFFF_FFFC, 32'd2);
    run_stream(1, 32'hFFFF_FFFF, 32'h11, 0, 100);
    n_vec++;
    if (addr_q.size() != 2 || addr_q[0] !== 32'hFFFF_FFFC || addr_q[1] !== 32'h0000_0000) begin
      n_err++; $display("FAIL wrap_addr: got %0d addrs second=%h, required FFFFFFFC,00000000",
                        addr_q.size(), addr_q.size() > 1 ? addr_q[1] : 32'hx);
    end
    n_vec++;
    if (beat_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL wrap_len: got %0d beats, required %0d", beat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < beat_q.size(); k++) begin
      n_vec++;
      if (beat_q[k] !== exp_q[k] || done_q[k] !== (k == exp_q.size() - 1)) begin
        n_err++; $display("FAIL wrap_beat%0d: out0=%h done=%b, required out0=%h", k, beat_q[k], done_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_count_zero();
    test_msb_first();
    test_reset_mid_emit();
    test_restart_fetch();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
